// File: rtl/onn_infer_ctrl.sv
// Inference sequencer for the 3x5 ONN: selects an image, counts the loader's
// serial bits, runs the oscillator array until it settles and returns the class.
module onn_infer_ctrl #(
    parameter int NBITS      = 60,
    parameter int IMG_W      = 3,
    parameter int RES_W      = 3,
    parameter int LOAD_TO    = 15,
    parameter int SETTLE_MAX = 1023
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IMG_W-1:0] req_img,
    output logic [IMG_W-1:0] img_no,
    output logic             re,
    output logic             start,
    input  logic             load,
    output logic             onn_run,
    input  logic             onn_settled,
    input  logic [RES_W-1:0] onn_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_class,
    output logic [IMG_W-1:0] res_img,
    output logic             res_timeout,
    output logic             res_err,
    output logic             busy
);

    localparam int BIT_W  = $clog2(NBITS + 1);
    localparam int WAIT_W = $clog2(LOAD_TO + 1);
    localparam int SET_W  = $clog2(SETTLE_MAX + 1);

    localparam logic [BIT_W-1:0]  BIT_FULL  = BIT_W'(NBITS);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOAD_TO - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_SHIFT,
        S_SETTLE,
        S_RESULT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [SET_W-1:0]  r_settle_cnt;
    logic              w_accept;
    logic              w_set_err;
    logic              w_set_to;
    logic              w_capture;

    assign w_accept = (r_state == S_IDLE) && req_valid;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        w_set_to  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) w_next = S_SEL;
            end
            S_SEL: begin
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                // Every loader protocol violation ends the pass with res_err set.
                if (load) begin
                    if (r_bit_cnt == BIT_FULL) begin
                        w_set_err = 1'b1;
                        w_next    = S_RESULT;
                    end
                end else if (r_bit_cnt == '0) begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_set_err = 1'b1;
                        w_next    = S_RESULT;
                    end
                end else if (r_bit_cnt == BIT_FULL) begin
                    w_next = S_SETTLE;
                end else begin
                    w_set_err = 1'b1;
                    w_next    = S_RESULT;
                end
            end
            S_SETTLE: begin
                // Convergence takes priority over a coincident timeout.
                if (onn_settled) begin
                    w_capture = 1'b1;
                    w_next    = S_RESULT;
                end else if (r_settle_cnt == SET_LAST) begin
                    w_capture = 1'b1;
                    w_set_to  = 1'b1;
                    w_next    = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_wait_cnt   <= '0;
            r_settle_cnt <= '0;
        end else if (r_state == S_SEL) begin
            r_bit_cnt    <= '0;
            r_wait_cnt   <= '0;
            r_settle_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            if (load && (r_bit_cnt != BIT_FULL)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (!load && (r_bit_cnt == '0) && (r_wait_cnt != WAIT_LAST)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end else if (r_state == S_SETTLE) begin
            if (r_settle_cnt != SET_LAST) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            img_no      <= '0;
            res_img     <= '0;
            res_class   <= '0;
            res_timeout <= 1'b0;
            res_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                img_no      <= req_img;
                res_img     <= req_img;
                res_timeout <= 1'b0;
                res_err     <= 1'b0;
            end
            if (w_set_err) res_err <= 1'b1;
            if (w_set_to) res_timeout <= 1'b1;
            if (w_capture) res_class <= onn_result;
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign re        = (r_state == S_SEL);
    assign start     = (r_state == S_SHIFT);
    assign onn_run   = (r_state == S_SETTLE);
    assign res_valid = (r_state == S_RESULT);

endmodule

// File: tb/tb_onn_infer_ctrl.sv
// Directed bench for onn_infer_ctrl: a default instance plus a SETTLE_MAX=16
// instance for the timeout and tie cases, selected through an output mux.
module tb_onn_infer_ctrl;

    logic       sclk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_img = '0;
    logic       load = 1'b0;
    logic       onn_settled = 1'b0;
    logic [2:0] onn_result = '0;
    logic       res_ready = 1'b0;
    logic       u = 1'b0;

    int checks = 0;
    int failures = 0;
    int n_re = 0;
    int n_start = 0;
    int n_run = 0;
    int run_base = 0;
    int re_base = 0;

    logic       a_req_ready, a_re, a_start, a_onn_run, a_res_valid, a_res_timeout, a_res_err, a_busy;
    logic [2:0] a_img_no, a_res_class, a_res_img;
    logic       b_req_ready, b_re, b_start, b_onn_run, b_res_valid, b_res_timeout, b_res_err, b_busy;
    logic [2:0] b_img_no, b_res_class, b_res_img;

    always #5 sclk = ~sclk;

    onn_infer_ctrl u_a (
        .sclk(sclk), .rst_n(rst_n), .req_valid(req_valid & ~u), .req_ready(a_req_ready),
        .req_img(req_img), .img_no(a_img_no), .re(a_re), .start(a_start), .load(load),
        .onn_run(a_onn_run), .onn_settled(onn_settled), .onn_result(onn_result),
        .res_valid(a_res_valid), .res_ready(res_ready), .res_class(a_res_class),
        .res_img(a_res_img), .res_timeout(a_res_timeout), .res_err(a_res_err), .busy(a_busy)
    );

    onn_infer_ctrl #(.SETTLE_MAX(16)) u_b (
        .sclk(sclk), .rst_n(rst_n), .req_valid(req_valid & u), .req_ready(b_req_ready),
        .req_img(req_img), .img_no(b_img_no), .re(b_re), .start(b_start), .load(load),
        .onn_run(b_onn_run), .onn_settled(onn_settled), .onn_result(onn_result),
        .res_valid(b_res_valid), .res_ready(res_ready), .res_class(b_res_class),
        .res_img(b_res_img), .res_timeout(b_res_timeout), .res_err(b_res_err), .busy(b_busy)
    );

    wire       m_req_ready   = u ? b_req_ready   : a_req_ready;
    wire       m_re          = u ? b_re          : a_re;
    wire       m_start       = u ? b_start       : a_start;
    wire       m_onn_run     = u ? b_onn_run     : a_onn_run;
    wire       m_res_valid   = u ? b_res_valid   : a_res_valid;
    wire       m_res_timeout = u ? b_res_timeout : a_res_timeout;
    wire       m_res_err     = u ? b_res_err     : a_res_err;
    wire       m_busy        = u ? b_busy        : a_busy;
    wire [2:0] m_img_no      = u ? b_img_no      : a_img_no;
    wire [2:0] m_res_class   = u ? b_res_class   : a_res_class;
    wire [2:0] m_res_img     = u ? b_res_img     : a_res_img;

    always @(negedge sclk) begin
        if (m_re === 1'b1) n_re <= n_re + 1;
        if (m_start === 1'b1) n_start <= n_start + 1;
        if (m_onn_run === 1'b1) n_run <= n_run + 1;
    end

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept a request, stream 60 bits with one wait cycle, stop in SETTLE cycle 1.
    task automatic front(input logic [2:0] img);
        int sb;
        re_base = n_re;
        sb = n_start;
        req_img = img;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        chk("sel_re", m_re, 1);
        chk("sel_img_no", m_img_no, img);
        chk("sel_start", m_start, 0);
        chk("sel_busy", m_busy, 1);
        chk("sel_err_clr", m_res_err, 0);
        tick;
        chk("shift_re", m_re, 0);
        chk("shift_start", m_start, 1);
        tick;
        load = 1'b1;
        repeat (60) tick;
        load = 1'b0;
        chk("shift_last", m_start, 1);
        tick;
        chk("settle_run", m_onn_run, 1);
        chk("settle_start", m_start, 0);
        chk("re_pulses", n_re - re_base, 1);
        chk("start_cycles", n_start - sb, 62);
        run_base = n_run;
    endtask

    task automatic handshake;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("hs_idle", m_req_ready, 1);
        chk("hs_valid", m_res_valid, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", m_req_ready, 1);
        chk("rst_busy", m_busy, 0);
        chk("rst_re", m_re, 0);
        chk("rst_start", m_start, 0);
        chk("rst_run", m_onn_run, 0);
        chk("rst_valid", m_res_valid, 0);
        chk("rst_img_no", m_img_no, 0);
        chk("rst_class", m_res_class, 0);
        chk("rst_res_img", m_res_img, 0);
        chk("rst_timeout", m_res_timeout, 0);
        chk("rst_err", m_res_err, 0);
        repeat (2) @(posedge sclk);
        #2 rst_n = 1'b1;
        tick;

        // nominal pass: settle on the 20th run cycle
        front(3'd3);
        repeat (19) tick;
        onn_settled = 1'b1;
        onn_result = 3'd5;
        tick;
        onn_settled = 1'b0;
        onn_result = 3'd0;
        chk("nom_valid", m_res_valid, 1);
        chk("nom_class", m_res_class, 5);
        chk("nom_img", m_res_img, 3);
        chk("nom_timeout", m_res_timeout, 0);
        chk("nom_err", m_res_err, 0);
        chk("nom_run_off", m_onn_run, 0);
        chk("nom_run_cycles", n_run - run_base, 20);
        handshake;
        chk("nom_busy", m_busy, 0);

        // load never rises
        req_img = 3'd1;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        repeat (14) tick;
        chk("wto_still_shift", m_start, 1);
        chk("wto_not_valid", m_res_valid, 0);
        tick;
        chk("wto_valid", m_res_valid, 1);
        chk("wto_err", m_res_err, 1);
        chk("wto_img", m_res_img, 1);
        chk("wto_timeout", m_res_timeout, 0);
        handshake;

        // load drops after 30 bits
        req_img = 3'd2;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        chk("drop_err_clr", m_res_err, 0);
        tick;
        load = 1'b1;
        repeat (30) tick;
        chk("drop_pre_valid", m_res_valid, 0);
        load = 1'b0;
        tick;
        chk("drop_valid", m_res_valid, 1);
        chk("drop_err", m_res_err, 1);
        handshake;

        // load stays high for 61 bits
        req_img = 3'd4;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        load = 1'b1;
        repeat (60) tick;
        chk("ovr_at60_shift", m_start, 1);
        chk("ovr_at60_valid", m_res_valid, 0);
        tick;
        load = 1'b0;
        chk("ovr_valid", m_res_valid, 1);
        chk("ovr_err", m_res_err, 1);
        handshake;

        // settle timeout on the SETTLE_MAX=16 instance
        u = 1'b1;
        front(3'd7);
        onn_result = 3'd2;
        repeat (15) tick;
        chk("sto_run16", m_onn_run, 1);
        onn_result = 3'd7;
        tick;
        onn_result = 3'd0;
        chk("sto_valid", m_res_valid, 1);
        chk("sto_timeout", m_res_timeout, 1);
        chk("sto_class", m_res_class, 7);
        chk("sto_err", m_res_err, 0);
        chk("sto_run_cycles", n_run - run_base, 16);
        handshake;

        // settled coincides with the last settle cycle
        front(3'd0);
        repeat (15) tick;
        onn_settled = 1'b1;
        onn_result = 3'd3;
        tick;
        onn_settled = 1'b0;
        onn_result = 3'd0;
        chk("tie_valid", m_res_valid, 1);
        chk("tie_timeout", m_res_timeout, 0);
        chk("tie_class", m_res_class, 3);
        chk("tie_run_cycles", n_run - run_base, 16);
        handshake;
        u = 1'b0;

        // backpressure with a pending request
        front(3'd5);
        onn_settled = 1'b1;
        onn_result = 3'd6;
        tick;
        onn_settled = 1'b0;
        req_valid = 1'b1;
        req_img = 3'd2;
        onn_result = 3'd1;
        re_base = n_re;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_valid", m_res_valid, 1);
            chk("bp_class", m_res_class, 6);
            chk("bp_img", m_res_img, 5);
            chk("bp_req_ready", m_req_ready, 0);
        end
        chk("bp_no_re", n_re - re_base, 0);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("bp_idle", m_req_ready, 1);
        chk("bp_idle_re", m_re, 0);
        tick;
        req_valid = 1'b0;
        chk("bp_next_re", m_re, 1);
        chk("bp_next_img", m_img_no, 2);

        // async reset in the middle of the stream
        tick;
        tick;
        load = 1'b1;
        repeat (25) tick;
        chk("mid_in_shift", m_start, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_start", m_start, 0);
        chk("arst_re", m_re, 0);
        chk("arst_run", m_onn_run, 0);
        chk("arst_valid", m_res_valid, 0);
        chk("arst_busy", m_busy, 0);
        chk("arst_req_ready", m_req_ready, 1);
        chk("arst_img_no", m_img_no, 0);
        chk("arst_res_img", m_res_img, 0);
        chk("arst_class", m_res_class, 0);
        load = 1'b0;
        tick;
        #2 rst_n = 1'b1;
        tick;

        front(3'd6);
        repeat (2) tick;
        onn_settled = 1'b1;
        onn_result = 3'd2;
        tick;
        onn_settled = 1'b0;
        chk("post_valid", m_res_valid, 1);
        chk("post_class", m_res_class, 2);
        chk("post_img", m_res_img, 6);
        chk("post_err", m_res_err, 0);
        chk("post_run_cycles", n_run - run_base, 3);
        handshake;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
